// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signal bundle for hazard_control_unit: hazard sources from ID/EX
// and the stall/flush/halt controls returned to the pipeline.
interface hazard_control_unit_if;
  logic       memRead_EX;
  logic [2:0] rdAddr_EX;
  logic [2:0] rsAddr_ID;
  logic [2:0] rtAddr_ID;
  logic       useRs_ID;
  logic       useRt_ID;
  logic       branchTaken_EX;
  logic       inputEnable_EX;
  logic       inputValid;
  logic       haltReq;
  logic       resume;
  logic       pcWrite;
  logic       IFIDWrite;
  logic       IFFlush;
  logic       IDFlush;
  logic       changeEnable;
  logic       inputAck;
  logic       halted;

  modport slave (
    input  memRead_EX, rdAddr_EX, rsAddr_ID, rtAddr_ID, useRs_ID, useRt_ID,
    input  branchTaken_EX, inputEnable_EX, inputValid, haltReq, resume,
    output pcWrite, IFIDWrite, IFFlush, IDFlush, changeEnable, inputAck, halted
  );

  modport master (
    output memRead_EX, rdAddr_EX, rsAddr_ID, rtAddr_ID, useRs_ID, useRt_ID,
    output branchTaken_EX, inputEnable_EX, inputValid, haltReq, resume,
    input  pcWrite, IFIDWrite, IFFlush, IDFlush, changeEnable, inputAck, halted
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, input wait and halt drain.
// Optional stall/flush statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_control_unit (
  input  logic                   clock,
  input  logic                   reset,
  hazard_control_unit_if.slave   hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]            stallCycles,
  output logic [15:0]            flushCycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_IN_WAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;

  logic load_use_s;
  logic pc_write_s;
  logic ifid_write_s;
  logic if_flush_s;
  logic id_flush_s;
  logic change_en_s;
  logic input_ack_s;
  logic halted_s;

  assign load_use_s = hz.memRead_EX &&
                      ((hz.useRs_ID && (hz.rsAddr_ID == hz.rdAddr_EX)) ||
                       (hz.useRt_ID && (hz.rtAddr_ID == hz.rdAddr_EX)));

  // State and drain counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state and control decode; reset forces safe bubble-inserting outputs
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    if_flush_s   = 1'b0;
    id_flush_s   = 1'b0;
    change_en_s  = 1'b1;
    input_ack_s  = 1'b0;
    halted_s     = 1'b0;
    if (reset) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      if_flush_s   = 1'b1;
      id_flush_s   = 1'b1;
      change_en_s  = 1'b0;
      state_d      = ST_RUN;
      drain_cnt_d  = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // A starved input read freezes EX, so a branch resolving there is not real yet
          if (hz.inputEnable_EX && !hz.inputValid) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            change_en_s  = 1'b0;
            state_d      = ST_IN_WAIT;
          end else if (hz.branchTaken_EX) begin
            if_flush_s  = 1'b1;
            id_flush_s  = 1'b1;
            input_ack_s = hz.inputEnable_EX;
          end else begin
            pc_write_s   = !load_use_s;
            ifid_write_s = !load_use_s;
            id_flush_s   = load_use_s;
            input_ack_s  = hz.inputEnable_EX;
            state_d      = hz.haltReq ? ST_DRAIN : ST_RUN;
            drain_cnt_d  = hz.haltReq ? 2'd3 : drain_cnt_q;
          end
        end
        ST_IN_WAIT: begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          change_en_s  = hz.inputValid;
          input_ack_s  = hz.inputValid;
          state_d      = hz.inputValid ? ST_RUN : ST_IN_WAIT;
        end
        ST_DRAIN: begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          id_flush_s   = 1'b1;
          drain_cnt_d  = (drain_cnt_q == 2'd0) ? 2'd0 : (drain_cnt_q - 2'd1);
          state_d      = (drain_cnt_q <= 2'd1) ? ST_HALTED : ST_DRAIN;
        end
        ST_HALTED: begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          change_en_s  = 1'b0;
          halted_s     = 1'b1;
          state_d      = hz.resume ? ST_RUN : ST_HALTED;
        end
        default: begin
          state_d     = ST_RUN;
          drain_cnt_d = 2'd0;
        end
      endcase
    end
  end

  assign hz.pcWrite      = pc_write_s;
  assign hz.IFIDWrite    = ifid_write_s;
  assign hz.IFFlush      = if_flush_s;
  assign hz.IDFlush      = id_flush_s;
  assign hz.changeEnable = change_en_s;
  assign hz.inputAck     = input_ack_s;
  assign hz.halted       = halted_s;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        stall_evt_s;
  logic        flush_evt_s;

  assign stall_evt_s = !pc_write_s && (state_q != ST_HALTED) && !reset;
  assign flush_evt_s = id_flush_s && !reset;

  // Saturating stall and flush statistics counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_evt_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_evt_s && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus random
// stimulus against a behavioural model. Output vector order is
// {pcWrite, IFIDWrite, IFFlush, IDFlush, changeEnable, inputAck, halted}.
module tb_hazard_control_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_control_unit_if hif();
`ifdef HAZARD_STATS_EN
  logic [15:0] stallCycles;
  logic [15:0] flushCycles;
`endif

  hazard_control_unit dut (
    .clock(clock),
    .reset(reset),
    .hz(hif)
`ifdef HAZARD_STATS_EN
    ,
    .stallCycles(stallCycles),
    .flushCycles(flushCycles)
`endif
  );

  localparam logic [6:0] O_RUN    = 7'b1100100;
  localparam logic [6:0] O_LU     = 7'b0001100;
  localparam logic [6:0] O_BR     = 7'b1111100;
  localparam logic [6:0] O_FROZEN = 7'b0000000;
  localparam logic [6:0] O_WACK   = 7'b0000110;
  localparam logic [6:0] O_RACK   = 7'b1100110;
  localparam logic [6:0] O_DRAIN  = 7'b0001100;
  localparam logic [6:0] O_HALT   = 7'b0000001;
  localparam logic [6:0] O_RST    = 7'b0011000;

  int total = 0;
  int bad = 0;

  // Behavioural model: pending input wait, drain cycles still owed, halted flag
  bit m_wait = 1'b0;
  int m_drain = 0;
  bit m_halt = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  logic [6:0] obs;
  assign obs = {hif.pcWrite, hif.IFIDWrite, hif.IFFlush, hif.IDFlush,
                hif.changeEnable, hif.inputAck, hif.halted};

  function automatic logic [6:0] model_out();
    logic hzd;
    logic [6:0] base;
    hzd = hif.memRead_EX &&
          ((hif.useRs_ID && hif.rsAddr_ID == hif.rdAddr_EX) ||
           (hif.useRt_ID && hif.rtAddr_ID == hif.rdAddr_EX));
    if (reset) return O_RST;
    if (m_halt) return O_HALT;
    if (m_drain > 0) return O_DRAIN;
    if (m_wait) return hif.inputValid ? O_WACK : O_FROZEN;
    if (hif.inputEnable_EX && !hif.inputValid) return O_FROZEN;
    base = hif.branchTaken_EX ? O_BR : (hzd ? O_LU : O_RUN);
    return base | {5'b00000, hif.inputEnable_EX, 1'b0};
  endfunction

  task automatic tick();
    logic [6:0] e;
    e = model_out();
    if (reset) begin
      m_wait = 1'b0; m_drain = 0; m_halt = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[6] && !m_halt && m_stall < 65535) m_stall++;
      if (e[3] && m_flush < 65535) m_flush++;
      if (m_halt) begin
        if (hif.resume) m_halt = 1'b0;
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halt = 1'b1;
      end else if (m_wait) begin
        if (hif.inputValid) m_wait = 1'b0;
      end else if (hif.inputEnable_EX && !hif.inputValid) begin
        m_wait = 1'b1;
      end else if (!hif.branchTaken_EX && hif.haltReq) begin
        m_drain = 3;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    hif.memRead_EX = 1'b0; hif.rdAddr_EX = 3'd0; hif.rsAddr_ID = 3'd0; hif.rtAddr_ID = 3'd0;
    hif.useRs_ID = 1'b0; hif.useRt_ID = 1'b0; hif.branchTaken_EX = 1'b0;
    hif.inputEnable_EX = 1'b0; hif.inputValid = 1'b0; hif.haltReq = 1'b0; hif.resume = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); tick(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); #1;
    total++; if (obs !== O_RST) begin bad++; $display("FAIL rst_out got=%b want=%b", obs, O_RST); end
    tick();
    hif.haltReq = 1'b1; hif.inputEnable_EX = 1'b1; hif.branchTaken_EX = 1'b1; #1;
    total++; if (obs !== O_RST) begin bad++; $display("FAIL rst_override got=%b want=%b", obs, O_RST); end
    tick();
    reset = 1'b0; idle(); #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL rst_release got=%b want=%b", obs, O_RUN); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    hif.memRead_EX = 1'b1; hif.rdAddr_EX = 3'd3; hif.useRs_ID = 1'b1; hif.rsAddr_ID = 3'd3; #1;
    total++; if (obs !== O_LU) begin bad++; $display("FAIL lu_stall got=%b want=%b", obs, O_LU); end
    tick();
    idle(); #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL lu_next got=%b want=%b", obs, O_RUN); end
    hif.memRead_EX = 1'b1; hif.rdAddr_EX = 3'd3; hif.useRs_ID = 1'b1; hif.rsAddr_ID = 3'd4; #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL lu_nomatch got=%b want=%b", obs, O_RUN); end
    hif.useRs_ID = 1'b0; hif.rsAddr_ID = 3'd3; hif.useRt_ID = 1'b1; hif.rtAddr_ID = 3'd3; #1;
    total++; if (obs !== O_LU) begin bad++; $display("FAIL lu_rt got=%b want=%b", obs, O_LU); end
    hif.memRead_EX = 1'b0; #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL lu_noload got=%b want=%b", obs, O_RUN); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    hif.memRead_EX = 1'b1; hif.rdAddr_EX = 3'd3; hif.useRs_ID = 1'b1; hif.rsAddr_ID = 3'd3;
    hif.branchTaken_EX = 1'b1; #1;
    total++; if (obs !== O_BR) begin bad++; $display("FAIL br_over_lu got=%b want=%b", obs, O_BR); end
    tick();
    idle(); hif.inputEnable_EX = 1'b1; hif.branchTaken_EX = 1'b1; #1;
    total++; if (obs !== O_FROZEN) begin bad++; $display("FAIL br_ignored_wait got=%b want=%b", obs, O_FROZEN); end
    tick();
    hif.branchTaken_EX = 1'b0; hif.inputValid = 1'b1; #1;
    total++; if (obs !== O_WACK) begin bad++; $display("FAIL br_wait_ack got=%b want=%b", obs, O_WACK); end
    tick();
    idle(); hif.branchTaken_EX = 1'b1; hif.haltReq = 1'b1; #1;
    total++; if (obs !== O_BR) begin bad++; $display("FAIL br_with_halt got=%b want=%b", obs, O_BR); end
    tick();
    idle(); #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL br_halt_dropped got=%b want=%b", obs, O_RUN); end
    tick();
  endtask

  task automatic test_input_wait();
    do_reset();
    hif.inputEnable_EX = 1'b1; hif.inputValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (obs !== O_FROZEN) begin bad++; $display("FAIL in_frozen%0d got=%b want=%b", i, obs, O_FROZEN); end
      tick();
    end
    hif.inputValid = 1'b1; #1;
    total++; if (obs !== O_WACK) begin bad++; $display("FAIL in_ack got=%b want=%b", obs, O_WACK); end
    tick();
    idle(); #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL in_back_run got=%b want=%b", obs, O_RUN); end
    hif.inputEnable_EX = 1'b1; hif.inputValid = 1'b1; #1;
    total++; if (obs !== O_RACK) begin bad++; $display("FAIL in_run_ack got=%b want=%b", obs, O_RACK); end
    tick();
    hif.inputValid = 1'b0; hif.haltReq = 1'b1; #1;
    total++; if (obs !== O_FROZEN) begin bad++; $display("FAIL in_halt_wait got=%b want=%b", obs, O_FROZEN); end
    tick(); #1;
    total++; if (obs !== O_FROZEN) begin bad++; $display("FAIL in_halt_deferred got=%b want=%b", obs, O_FROZEN); end
    tick();
    hif.inputValid = 1'b1; #1;
    total++; if (obs !== O_WACK) begin bad++; $display("FAIL in_halt_ack got=%b want=%b", obs, O_WACK); end
    tick();
    hif.inputEnable_EX = 1'b0; hif.inputValid = 1'b0; #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL in_halt_run got=%b want=%b", obs, O_RUN); end
    tick();
    hif.haltReq = 1'b0; #1;
    total++; if (obs !== O_DRAIN) begin bad++; $display("FAIL in_deferred_drain got=%b want=%b", obs, O_DRAIN); end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    hif.haltReq = 1'b1; #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL halt_req_cycle got=%b want=%b", obs, O_RUN); end
    tick();
    hif.haltReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (obs !== O_DRAIN) begin bad++; $display("FAIL halt_drain%0d got=%b want=%b", i, obs, O_DRAIN); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      hif.haltReq = i[0]; hif.inputEnable_EX = 1'b1; hif.inputValid = 1'b1; #1;
      total++; if (obs !== O_HALT) begin bad++; $display("FAIL halt_hold%0d got=%b want=%b", i, obs, O_HALT); end
      tick();
    end
    idle(); hif.resume = 1'b1; #1;
    total++; if (obs !== O_HALT) begin bad++; $display("FAIL halt_resume_cycle got=%b want=%b", obs, O_HALT); end
    tick();
    hif.resume = 1'b0; #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL halt_after_resume got=%b want=%b", obs, O_RUN); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    hif.haltReq = 1'b1; tick();
    hif.haltReq = 1'b0; tick();
    reset = 1'b1; #1;
    total++; if (obs !== O_RST) begin bad++; $display("FAIL mdr_rst got=%b want=%b", obs, O_RST); end
    tick();
    hif.haltReq = 1'b1; hif.inputEnable_EX = 1'b1; #1;
    total++; if (obs !== O_RST) begin bad++; $display("FAIL mdr_rst_hold got=%b want=%b", obs, O_RST); end
    tick();
    reset = 1'b0; idle(); #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL mdr_run got=%b want=%b", obs, O_RUN); end
    hif.inputEnable_EX = 1'b1; tick();
    reset = 1'b1; tick();
    reset = 1'b0; idle(); #1;
    total++; if (obs !== O_RUN) begin bad++; $display("FAIL mwait_run got=%b want=%b", obs, O_RUN); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] e;
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      hif.memRead_EX = 1'($urandom_range(0, 1));
      hif.rdAddr_EX = 3'($urandom_range(0, 3));
      hif.rsAddr_ID = 3'($urandom_range(0, 3));
      hif.rtAddr_ID = 3'($urandom_range(0, 3));
      hif.useRs_ID = 1'($urandom_range(0, 1));
      hif.useRt_ID = 1'($urandom_range(0, 1));
      hif.branchTaken_EX = ($urandom_range(0, 4) == 0);
      hif.inputEnable_EX = ($urandom_range(0, 3) == 0);
      hif.inputValid = ($urandom_range(0, 2) != 0);
      hif.haltReq = ($urandom_range(0, 9) == 0);
      hif.resume = ($urandom_range(0, 3) == 0);
      #1;
      e = model_out();
      total++; if (obs !== e) begin bad++; $display("FAIL rnd_out cyc=%0d got=%b want=%b", i, obs, e); end
`ifdef HAZARD_STATS_EN
      total++; if (stallCycles !== m_stall[15:0]) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%0d want=%0d", i, stallCycles, m_stall); end
      total++; if (flushCycles !== m_flush[15:0]) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%0d want=%0d", i, flushCycles, m_flush); end
`endif
      tick();
    end
    reset = 1'b0;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset(); #1;
    total++; if (stallCycles !== 16'd0) begin bad++; $display("FAIL st_reset got=%0d want=0", stallCycles); end
    hif.memRead_EX = 1'b1; hif.rdAddr_EX = 3'd3; hif.useRs_ID = 1'b1; hif.rsAddr_ID = 3'd3;
    repeat (5) tick();
    idle(); #1;
    total++; if (stallCycles !== 16'd5) begin bad++; $display("FAIL st_stall5 got=%0d want=5", stallCycles); end
    total++; if (flushCycles !== 16'd5) begin bad++; $display("FAIL st_flush5 got=%0d want=5", flushCycles); end
    hif.inputEnable_EX = 1'b1; hif.inputValid = 1'b0;
    repeat (70000) tick();
    #1;
    total++; if (stallCycles !== 16'hFFFF) begin bad++; $display("FAIL st_saturate got=%h want=ffff", stallCycles); end
    total++; if (flushCycles !== 16'd5) begin bad++; $display("FAIL st_flush_hold got=%0d want=5", flushCycles); end
    reset = 1'b1; tick(); reset = 1'b0; idle(); #1;
    total++; if (stallCycles !== 16'd0) begin bad++; $display("FAIL st_clear got=%0d want=0", stallCycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_input_wait();
    test_halt();
    test_reset_mid_drain();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
